mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of bus_addr, pc and alu_addr.
REQ-002 Parameter: DATA_W, fixed 32, width of the bus data, the instruction register and the data register.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_start  input  1  one-cycle pulse that requests an access; sampled only in IDLE.
REQ-006 IorD  input  1  0 = instruction fetch at pc; 1 = data access at alu_addr.
REQ-007 MemWrite  input  1  1 = store; sampled with mem_start; a store requires IorD=1.
REQ-008 funct3  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-009 pc, alu_addr  input  ADDR_W  fetch address and data address.
REQ-010 wdata  input  32  store data (rs2 value), right-aligned.
REQ-011 bus_req, bus_we  output  1  bus request and write enable.
REQ-012 bus_addr  output  ADDR_W  word-aligned address, low two bits always 0.
REQ-013 bus_be  output  4  byte enables; bus_wdata  output  32  lane-shifted store data.
REQ-014 bus_rdata  input  32 and bus_ack  input  1  response data and one-cycle completion.
REQ-015 instr_reg  output  32  last fetched instruction.
REQ-016 data_reg  output  32  last load result, extended to 32 bits.
REQ-017 busy  output  1  high while not in IDLE.
REQ-018 done  output  1  one-cycle pulse when an access completes.
REQ-019 misalign  output  1  sticky flag for a misaligned access.

Function
REQ-020 The FSM SHALL have three states, IDLE, REQ and RESP; mem_start in IDLE moves it to REQ on the next edge.
REQ-021 On leaving IDLE, the unit SHALL latch the address (pc if IorD=0, else alu_addr), MemWrite, funct3 and wdata; input changes after that SHALL have no effect.
REQ-022 In REQ, bus_req SHALL be held high with stable bus_addr, bus_we, bus_be and bus_wdata until bus_ack=1, for an unbounded wait.
REQ-023 bus_ack=1 in REQ SHALL capture the read data and move the FSM to RESP; bus_ack outside REQ SHALL be ignored.
REQ-024 In RESP, done SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; minimum latency is mem_start to done = 2 cycles with ack in the first REQ cycle.
REQ-025 On a fetch (IorD=0), instr_reg SHALL be loaded from bus_rdata; data_reg SHALL be unchanged.
REQ-026 On a data load, data_reg SHALL be loaded from the lane selected by addr[1:0] and extended as follows:
- lb/lh: sign-extended;
- lbu/lhu: zero-extended;
- lw: full word.
REQ-027 On a store, bus_be SHALL be 0001<<addr[1:0] for sb, 0011<<addr[1:0] for sh and 1111 for sw.
REQ-028 On a store, bus_wdata SHALL be wdata shifted left by 8*addr[1:0]; instr_reg and data_reg SHALL be unchanged.
REQ-029 A fetch SHALL always use a full-word access with bus_be=1111, regardless of funct3.
REQ-030 An undefined funct3 (011, 110, 111) SHALL be treated as a word access.
REQ-031 mem_start while busy SHALL be ignored, with no queueing.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, including instr_reg, data_reg and misalign.
REQ-033 Reset asserted mid-transaction SHALL drop bus_req immediately and discard the access without asserting done.
REQ-034 The first mem_start SHALL be accepted on the first rising edge after reset returns to 1.

Configuration
REQ-035 Macro MISALIGN_CHK_EN defined: a halfword access with addr[0]=1, or a word/fetch access with addr[1:0]!=00, SHALL skip REQ, go directly to RESP, assert done and set misalign.
REQ-036 With MISALIGN_CHK_EN defined, a misaligned access SHALL issue no bus_req and leave instr_reg and data_reg unchanged; misalign SHALL clear only on reset.
REQ-037 Macro MISALIGN_CHK_EN undefined: misalign SHALL be tied to 0, and misaligned accesses SHALL proceed with the low address bits applied to lane selection only.

Verification
REQ-038 Fetch: IorD=0, pc=0x100, bus_rdata=0x00A00093 with ack after 3 REQ cycles -> bus_addr=0x100, bus_be=1111, instr_reg=0x00A00093, done 4 cycles after leaving IDLE.
REQ-039 Signed byte load: lb at alu_addr=0x203, bus_rdata=0x80FF1234 -> bus_addr=0x200, data_reg=0xFFFFFF80; the same access as lbu -> data_reg=0x00000080.
REQ-040 Halfword store: sh at alu_addr=0x2, wdata=0x0000BEEF -> bus_we=1, bus_be=1100, bus_wdata=0xBEEF0000, data_reg unchanged.
REQ-041 Mid-access reset: reset=0 while in REQ -> bus_req=0 immediately, done never asserted, instr_reg=0.
REQ-042 MISALIGN_CHK_EN defined, lw at 0x6 -> no bus_req, done after 1 cycle, misalign=1 held until reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port memory access sequencer for a multicycle RV32 core.
// Handles instruction fetches and byte/halfword/word loads and stores on a simple
// req/ack bus. An access is latched on mem_start in IDLE, held on the bus in REQ
// until bus_ack, and reported with a one-cycle done in RESP.
// Optional feature: define MISALIGN_CHK_EN to trap misaligned halfword/word/fetch
// accesses (no bus traffic, done asserted, sticky misalign flag set).
module mem_access_unit #(
  parameter int ADDR_W = 32,
  localparam int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_start,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [DATA_W-1:0] instr_reg,
  output logic [DATA_W-1:0] data_reg,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state, state_next;

  // Access attributes captured when the FSM leaves IDLE.
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              fetch_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] start_addr;
  logic              start_bad;
  logic              accept;
  logic              capture;
  logic [1:0]        off;
  logic [4:0]        shamt;
  logic              is_byte;
  logic              is_half;
  logic [3:0]        be_acc;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_val;

  assign start_addr = IorD ? alu_addr : pc;
  assign accept     = (state == IDLE) && mem_start;
  assign capture    = (state == REQ) && bus_ack;
  assign off        = addr_q[1:0];
  assign shamt      = {off, 3'b000};

  // Size decode: fetches and undefined funct3 encodings fall through to word.
  assign is_byte = !fetch_q && (f3_q[1:0] == 2'b00);
  assign is_half = !fetch_q && (f3_q[1:0] == 2'b01);

`ifdef MISALIGN_CHK_EN
  // Misalignment test on the incoming request, using the same size rules.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    start_bad = 1'b0;
    if (!IorD) begin
      start_bad = (start_addr[1:0] != 2'b00);
    end else begin
      case (funct3[1:0])
        2'b00:   start_bad = 1'b0;
        2'b01:   start_bad = start_addr[0];
        default: start_bad = (start_addr[1:0] != 2'b00);
      endcase
    end
  end

  // Sticky misalign flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign <= 1'b0;
    end else if (accept && start_bad) begin
      misalign <= 1'b1;
    end
  end
`else
  assign start_bad = 1'b0;
  assign misalign  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= state_next;
    end
  end

  // Next-state logic; a trapped misaligned access bypasses the bus entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_start) state_next = start_bad ? RESP : REQ;
      REQ:  if (bus_ack)   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request so later input changes cannot disturb the bus cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these are plain flops, not a memory array, so clearing them on reset is cheap
      // and keeps the bus outputs deterministic; a RAM would not be reset.
      addr_q  <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      f3_q    <= 3'b000;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= start_addr;
      we_q    <= MemWrite && IorD;
      fetch_q <= !IorD;
      f3_q    <= funct3;
      wdata_q <= wdata;
    end
  end

  // Byte enables: fetches and word accesses use all lanes.
  always_comb begin
    be_acc = 4'b1111;
    if (is_byte) begin
      be_acc = 4'b0001 << off;
    end else if (is_half) begin
      be_acc = 4'b0011 << off;
    end
  end

  // Load alignment and extension from the addressed lane.
  always_comb begin
    lane     = bus_rdata >> shamt;
    load_val = lane;
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'h000000, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'h0000, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // Result registers, written only when the bus acknowledges a fetch or a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_reg <= '0;
      data_reg  <= '0;
    end else if (capture) begin
      if (fetch_q) begin
        instr_reg <= bus_rdata;
      end else if (!we_q) begin
        data_reg <= load_val;
      end
    end
  end

  // Bus outputs are driven only in REQ, so reset drops them immediately.
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req && we_q;
  assign bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be_acc : 4'b0000;
  assign bus_wdata = bus_we ? (wdata_q << shamt) : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == RESP);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: fetch, loads with extension, stores with
// lane shifting, ignored mem_start/ack, misaligned handling and mid-access reset.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_start;
  logic        IorD;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] alu_addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] instr_reg;
  logic [31:0] data_reg;
  logic        busy;
  logic        done;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_start (mem_start),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .pc        (pc),
    .alu_addr  (alu_addr),
    .wdata     (wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .instr_reg (instr_reg),
    .data_reg  (data_reg),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; returns at the falling edge of the first cycle after IDLE.
  // Inputs are scrambled afterwards to prove the unit latched them.
  task automatic start(input logic iord, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    IorD      = iord;
    MemWrite  = we;
    funct3    = f3;
    if (iord) alu_addr = addr;
    else      pc       = addr;
    wdata     = wd;
    mem_start = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    IorD      = ~iord;
    MemWrite  = ~we;
    funct3    = 3'b111;
    pc        = 32'hDEAD_0000;
    alu_addr  = 32'hBAD0_0003;
    wdata     = 32'h5555_5555;
  endtask

  // Hold off ack for 'waits' REQ cycles, then ack with rd; checks the done pulse.
  task automatic respond(input int waits, input logic [31:0] rd);
    for (int i = 0; i < waits; i++) begin
      check("wait_req", {31'b0, bus_req}, 32'd1);
      check("wait_done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    bus_rdata = rd;
    bus_ack   = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("resp_no_req", {31'b0, bus_req}, 32'd0);
    @(negedge clk);
    check("done_clear", {31'b0, done}, 32'd0);
    check("back_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    mem_start = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'b000;
    pc        = 32'h0;
    alu_addr  = 32'h0;
    wdata     = 32'h0;
    bus_rdata = 32'h0;
    bus_ack   = 1'b0;

    // Reset state: everything zero.
    #2;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_we", {31'b0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", {28'b0, bus_be}, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_instr", instr_reg, 32'h0);
    check("rst_data", data_reg, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Fetch at 0x100, funct3 forced to a byte code, ack after 3 wait cycles.
    start(1'b0, 1'b0, 3'b000, 32'h100, 32'h0);
    check("f_busy", {31'b0, busy}, 32'd1);
    check("f_addr", bus_addr, 32'h100);
    check("f_be", {28'b0, bus_be}, 32'hF);
    check("f_we", {31'b0, bus_we}, 32'd0);
    @(negedge clk);
    check("f_addr_held", bus_addr, 32'h100);
    respond(2, 32'h00A0_0093);
    check("f_instr", instr_reg, 32'h00A0_0093);
    check("f_data_keep", data_reg, 32'h0);

    // lb at 0x203 -> byte 0x80 sign-extended, minimum latency.
    start(1'b1, 1'b0, 3'b000, 32'h203, 32'h0);
    check("lb_addr", bus_addr, 32'h200);
    check("lb_be", {28'b0, bus_be}, 32'h8);
    respond(0, 32'h80FF_1234);
    check("lb_data", data_reg, 32'hFFFF_FF80);
    check("lb_instr_keep", instr_reg, 32'h00A0_0093);

    // lbu at 0x203 -> zero-extended.
    start(1'b1, 1'b0, 3'b100, 32'h203, 32'h0);
    respond(0, 32'h80FF_1234);
    check("lbu_data", data_reg, 32'h0000_0080);

    // lbu at 0x201 -> byte 0x12.
    start(1'b1, 1'b0, 3'b100, 32'h201, 32'h0);
    respond(1, 32'h80FF_1234);
    check("lbu1_data", data_reg, 32'h0000_0012);

    // lh at 0x202 -> upper half 0x80FF sign-extended.
    start(1'b1, 1'b0, 3'b001, 32'h202, 32'h0);
    check("lh_be", {28'b0, bus_be}, 32'hC);
    respond(0, 32'h80FF_1234);
    check("lh_data", data_reg, 32'hFFFF_80FF);

    // lhu at 0x200 -> lower half zero-extended.
    start(1'b1, 1'b0, 3'b101, 32'h200, 32'h0);
    check("lhu_be", {28'b0, bus_be}, 32'h3);
    respond(0, 32'h80FF_9234);
    check("lhu_data", data_reg, 32'h0000_9234);

    // lw at 0x204.
    start(1'b1, 1'b0, 3'b010, 32'h204, 32'h0);
    check("lw_addr", bus_addr, 32'h204);
    respond(0, 32'hDEAD_BEEF);
    check("lw_data", data_reg, 32'hDEAD_BEEF);

    // Undefined funct3 111 behaves as a word load.
    start(1'b1, 1'b0, 3'b111, 32'h208, 32'h0);
    check("u3_be", {28'b0, bus_be}, 32'hF);
    respond(0, 32'h0123_4567);
    check("u3_data", data_reg, 32'h0123_4567);

    // sh at 0x2 with 0xBEEF.
    start(1'b1, 1'b1, 3'b001, 32'h2, 32'h0000_BEEF);
    check("sh_we", {31'b0, bus_we}, 32'd1);
    check("sh_addr", bus_addr, 32'h0);
    check("sh_be", {28'b0, bus_be}, 32'hC);
    check("sh_wdata", bus_wdata, 32'hBEEF_0000);
    respond(1, 32'h7777_7777);
    check("sh_data_keep", data_reg, 32'h0123_4567);
    check("sh_instr_keep", instr_reg, 32'h00A0_0093);

    // sb at 0x1 with 0xAB.
    start(1'b1, 1'b1, 3'b000, 32'h1, 32'h0000_00AB);
    check("sb_be", {28'b0, bus_be}, 32'h2);
    check("sb_wdata", bus_wdata, 32'h0000_AB00);
    respond(0, 32'h0);

    // sw at 0x10.
    start(1'b1, 1'b1, 3'b010, 32'h10, 32'h1122_3344);
    check("sw_addr", bus_addr, 32'h10);
    check("sw_be", {28'b0, bus_be}, 32'hF);
    check("sw_wdata", bus_wdata, 32'h1122_3344);
    respond(0, 32'h0);
    check("sw_data_keep", data_reg, 32'h0123_4567);

    // mem_start while busy is dropped, not queued.
    start(1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
    IorD      = 1'b1;
    alu_addr  = 32'h80;
    mem_start = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    check("busy_ign_addr", bus_addr, 32'h40);
    respond(0, 32'h0000_0013);
    check("busy_ign_instr", instr_reg, 32'h0000_0013);
    @(negedge clk);
    check("busy_ign_noq", {31'b0, busy}, 32'd0);

    // bus_ack in IDLE is ignored.
    bus_rdata = 32'h1234_5678;
    bus_ack   = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b0;
    check("ack_idle_busy", {31'b0, busy}, 32'd0);
    check("ack_idle_data", data_reg, 32'h0123_4567);
    check("ack_idle_instr", instr_reg, 32'h0000_0013);

    // Misaligned lw at 0x6.
`ifdef MISALIGN_CHK_EN
    start(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    check("mis_no_req", {31'b0, bus_req}, 32'd0);
    check("mis_done", {31'b0, done}, 32'd1);
    check("mis_flag", {31'b0, misalign}, 32'd1);
    @(negedge clk);
    check("mis_done_clear", {31'b0, done}, 32'd0);
    check("mis_data_keep", data_reg, 32'h0123_4567);
    start(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    respond(0, 32'hAAAA_5555);
    check("mis_sticky", {31'b0, misalign}, 32'd1);
`else
    start(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    check("mis_req", {31'b0, bus_req}, 32'd1);
    check("mis_addr", bus_addr, 32'h4);
    check("mis_flag0", {31'b0, misalign}, 32'd0);
    respond(0, 32'h1122_3344);
    check("mis_flag0_after", {31'b0, misalign}, 32'd0);
`endif

    // Mid-access reset: bus_req drops at once and done never fires.
    start(1'b0, 1'b0, 3'b010, 32'h500, 32'h0);
    check("mr_req", {31'b0, bus_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("mr_req_drop", {31'b0, bus_req}, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_instr", instr_reg, 32'h0);
    check("mr_data", data_reg, 32'h0);
    check("mr_misalign", {31'b0, misalign}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mr_no_done", {31'b0, done}, 32'd0);
    end

    // First mem_start accepted on the first edge after reset releases.
    IorD      = 1'b0;
    pc        = 32'h600;
    mem_start = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    check("post_rst_busy", {31'b0, busy}, 32'd1);
    check("post_rst_addr", bus_addr, 32'h600);
    respond(0, 32'hCAFE_F00D);
    check("post_rst_instr", instr_reg, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
